// File: rtl/latch_bank_hold_pkg.sv
// Shared types and helpers for the latch_bank_hold capture bank.
// Holds the lane state encoding, the counter sizing function and the default reset value.
package latch_bank_hold_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HELD  = 2'd1;
  localparam logic [1:0] ST_OPEN  = 2'd2;

  localparam int DEF_RESET_VAL = 0;

  // A zero-length hold still needs a 1-bit counter.
  function automatic int cnt_width(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/latch_bank_hold_if.sv
// Bus bundle for latch_bank_hold: d/en/freeze/clear in, q/valid/changed/busy out.
// The master drives the requests, and the slave (the bank) drives the lane state.
interface latch_bank_hold_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic [CHANNELS*WIDTH-1:0] d;
  logic [CHANNELS-1:0]       en;
  logic                      freeze;
  logic                      clear;
  logic [CHANNELS*WIDTH-1:0] q;
  logic [CHANNELS-1:0]       valid;
  logic [CHANNELS-1:0]       changed;
  logic [CHANNELS-1:0]       busy;

  modport master (
    output d, en, freeze, clear,
    input  q, valid, changed, busy
  );

  modport slave (
    input  d, en, freeze, clear,
    output q, valid, changed, busy
  );
endinterface

// File: rtl/latch_bank_lane.sv
// One capture lane: the data register, the hold counter and the valid/changed/busy flags.
// Ports: clock/reset, d/en/freeze/clear in, q/valid/changed/busy out.
module latch_bank_lane
  import latch_bank_hold_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               HOLD      = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             freeze,
  input  logic             clear,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             changed,
  output logic             busy
);

  localparam int            CW     = cnt_width(HOLD);
  localparam logic [CW-1:0] HOLD_C = CW'(HOLD);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [1:0]    ST_CAP = (HOLD > 0) ? ST_HELD : ST_OPEN;

  logic [CW-1:0] cnt;
  logic [1:0]    st;
  logic          cap;

  assign cap   = en & ~freeze & ~clear & (cnt == '0);
  assign valid = (st != ST_EMPTY);
  assign busy  = (cnt != '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q       <= RESET_VAL;
      st      <= ST_EMPTY;
      cnt     <= '0;
      changed <= 1'b0;
    end else if (clear) begin
      q       <= RESET_VAL;
      st      <= ST_EMPTY;
      cnt     <= '0;
      changed <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (cnt != '0) cnt <= cnt - ONE;
      if (st == ST_HELD && cnt == ONE) st <= ST_OPEN;
      // cap needs cnt==0, so it never collides with the decrement
      if (cap) begin
        q       <= d;
        cnt     <= HOLD_C;
        st      <= ST_CAP;
        changed <= (st == ST_EMPTY) || (d != q);
      end
    end
  end

endmodule

// File: rtl/latch_bank_hold.sv
// Multi-lane capture register bank with per-lane hold lockout.
// Ports: clock, reset (async, active-high), bus (slave: d/en/freeze/clear in, q/valid/changed/busy out).
module latch_bank_hold
  import latch_bank_hold_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CHANNELS  = 4,
  parameter int               HOLD      = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
  input logic               clock,
  input logic               reset,
  latch_bank_hold_if.slave  bus
);

  logic [WIDTH-1:0] q_l  [CHANNELS];
  logic             v_l  [CHANNELS];
  logic             c_l  [CHANNELS];
  logic             b_l  [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    latch_bank_lane #(
      .WIDTH     (WIDTH),
      .HOLD      (HOLD),
      .RESET_VAL (RESET_VAL)
    ) u_lane (
      .clock   (clock),
      .reset   (reset),
      .d       (bus.d[i*WIDTH +: WIDTH]),
      .en      (bus.en[i]),
      .freeze  (bus.freeze),
      .clear   (bus.clear),
      .q       (q_l[i]),
      .valid   (v_l[i]),
      .changed (c_l[i]),
      .busy    (b_l[i])
    );
  end

  always_comb begin
    bus.q       = '0;
    bus.valid   = '0;
    bus.changed = '0;
    bus.busy    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.q[i*WIDTH +: WIDTH] = q_l[i];
      bus.valid[i]            = v_l[i];
      bus.changed[i]          = c_l[i];
      bus.busy[i]             = b_l[i];
    end
  end

endmodule

// File: tb/tb_latch_bank_hold.sv
// Directed-vector bench for latch_bank_hold: HOLD=3 bank (4x8) plus a HOLD=0 bank (2x8).
// Ports exercised through two latch_bank_hold_if instances.
module tb_latch_bank_hold;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  latch_bank_hold_if #(.WIDTH(8), .CHANNELS(4)) bus ();
  latch_bank_hold_if #(.WIDTH(8), .CHANNELS(2)) hb ();

  latch_bank_hold #(
    .WIDTH(8), .CHANNELS(4), .HOLD(3), .RESET_VAL(8'h00)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  latch_bank_hold #(
    .WIDTH(8), .CHANNELS(2), .HOLD(0), .RESET_VAL(8'h5A)
  ) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (hb.slave)
  );

  typedef struct {
    logic [3:0]  en;
    logic        frz;
    logic        clr;
    logic [31:0] d;
    logic [31:0] eq;
    logic [3:0]  ev;
    logic [3:0]  ec;
    logic [3:0]  eb;
  } vec_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] en, input logic frz,
                              input logic clr, input logic [31:0] d,
                              input logic [31:0] eq, input logic [3:0] ev,
                              input logic [3:0] ec, input logic [3:0] eb);
    vec_t v;
    v.en = en; v.frz = frz; v.clr = clr; v.d = d;
    v.eq = eq; v.ev = ev; v.ec = ec; v.eb = eb;
    return v;
  endfunction

  task automatic chk_bank(input string tag, input logic [31:0] eq,
                          input logic [3:0] ev, input logic [3:0] ec,
                          input logic [3:0] eb);
    chk({tag, "_q"}, bus.q, eq);
    chk({tag, "_valid"}, {28'd0, bus.valid}, {28'd0, ev});
    chk({tag, "_changed"}, {28'd0, bus.changed}, {28'd0, ec});
    chk({tag, "_busy"}, {28'd0, bus.busy}, {28'd0, eb});
  endtask

  vec_t tv [19];
  logic [7:0]  hd [5];
  logic [1:0]  hen [5];
  logic [15:0] hq [5];
  logic [1:0]  hv [5];
  logic [1:0]  hc [5];

  initial begin
    tv[0]  = mk(4'b0001, 0, 0, 32'h000000A5, 32'h000000A5, 4'b0001, 4'b0001, 4'b0001);
    tv[1]  = mk(4'b0001, 0, 0, 32'h0000003C, 32'h000000A5, 4'b0001, 4'b0000, 4'b0001);
    tv[2]  = mk(4'b0001, 0, 0, 32'h0000003C, 32'h000000A5, 4'b0001, 4'b0000, 4'b0001);
    tv[3]  = mk(4'b0001, 0, 0, 32'h0000003C, 32'h000000A5, 4'b0001, 4'b0000, 4'b0000);
    tv[4]  = mk(4'b0001, 0, 0, 32'h0000003C, 32'h0000003C, 4'b0001, 4'b0001, 4'b0001);
    tv[5]  = mk(4'b0000, 0, 0, 32'h0000003C, 32'h0000003C, 4'b0001, 4'b0000, 4'b0001);
    tv[6]  = mk(4'b0000, 0, 0, 32'h0000003C, 32'h0000003C, 4'b0001, 4'b0000, 4'b0001);
    tv[7]  = mk(4'b0000, 0, 0, 32'h0000003C, 32'h0000003C, 4'b0001, 4'b0000, 4'b0000);
    tv[8]  = mk(4'b0001, 0, 0, 32'h0000003C, 32'h0000003C, 4'b0001, 4'b0000, 4'b0001);
    tv[9]  = mk(4'b1111, 1, 0, 32'h11223344, 32'h0000003C, 4'b0001, 4'b0000, 4'b0001);
    tv[10] = mk(4'b1111, 1, 0, 32'h11223344, 32'h0000003C, 4'b0001, 4'b0000, 4'b0001);
    tv[11] = mk(4'b1111, 1, 0, 32'h11223344, 32'h0000003C, 4'b0001, 4'b0000, 4'b0000);
    tv[12] = mk(4'b0110, 0, 0, 32'h11223344, 32'h0022333C, 4'b0111, 4'b0110, 4'b0110);
    tv[13] = mk(4'b1111, 0, 1, 32'hAABBCCDD, 32'h00000000, 4'b0000, 4'b0000, 4'b0000);
    tv[14] = mk(4'b1000, 0, 0, 32'h80000000, 32'h80000000, 4'b1000, 4'b1000, 4'b1000);
    tv[15] = mk(4'b1111, 0, 0, 32'h12345678, 32'h80345678, 4'b1111, 4'b0111, 4'b1111);
    tv[16] = mk(4'b0000, 0, 0, 32'h00000000, 32'h80345678, 4'b1111, 4'b0000, 4'b1111);
    tv[17] = mk(4'b1111, 0, 0, 32'h00000000, 32'h80345678, 4'b1111, 4'b0000, 4'b0111);
    tv[18] = mk(4'b1000, 0, 0, 32'h80000000, 32'h80345678, 4'b1111, 4'b0000, 4'b1000);

    hd  = '{8'h00, 8'h01, 8'h02, 8'h02, 8'h07};
    hen = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    hq  = '{16'h5A00, 16'h5A01, 16'h5A02, 16'h5A02, 16'h5A02};
    hv  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    hc  = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00};

    bus.d = '0; bus.en = '0; bus.freeze = 1'b0; bus.clear = 1'b0;
    hb.d = '0; hb.en = '0; hb.freeze = 1'b0; hb.clear = 1'b0;

    #12;
    chk_bank("rst", 32'h0, 4'b0, 4'b0, 4'b0);
    chk("rst_h0_q", {16'd0, hb.q}, 32'h00005A5A);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      bus.en = tv[i].en; bus.freeze = tv[i].frz;
      bus.clear = tv[i].clr; bus.d = tv[i].d;
      @(posedge clock); #1;
      chk_bank($sformatf("v%0d", i), tv[i].eq, tv[i].ev, tv[i].ec, tv[i].eb);
    end
    bus.en = '0;

    // asynchronous reset mid-cycle with lanes populated
    #3 reset = 1'b1;
    #1 chk_bank("arst", 32'h0, 4'b0, 4'b0, 4'b0);
    bus.en = 4'b1111; bus.d = 32'hFFFFFFFF;
    @(posedge clock); #1;
    chk_bank("arst_hi", 32'h0, 4'b0, 4'b0, 4'b0);
    #2 reset = 1'b0;
    @(posedge clock); #1;
    chk_bank("arst_rel", 32'hFFFFFFFF, 4'b1111, 4'b1111, 4'b1111);
    bus.en = '0;

    // HOLD=0 bank: capture on every enabled edge, never busy
    for (int i = 0; i < 5; i++) begin
      hb.en = hen[i]; hb.d = {8'h00, hd[i]};
      @(posedge clock); #1;
      chk($sformatf("h0_%0d_q", i), {16'd0, hb.q}, {16'd0, hq[i]});
      chk($sformatf("h0_%0d_valid", i), {30'd0, hb.valid}, {30'd0, hv[i]});
      chk($sformatf("h0_%0d_changed", i), {30'd0, hb.changed}, {30'd0, hc[i]});
      chk($sformatf("h0_%0d_busy", i), {30'd0, hb.busy}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
